// File: rtl/syllable_packer.sv
// Devanagari syllable packer: groups letter codes into conjunct
// clusters with optional vowel sign and word-end marker.
module syllable_packer #(
  parameter int CODE_W = 7,
  parameter int MAX_HALF = 2,
  parameter logic [CODE_W-1:0] SPACE_CODE = 7'b0110000,
  localparam int NW = $clog2(MAX_HALF + 2),
  localparam int CW = (MAX_HALF + 1) * CODE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_half,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW-1:0]     out_cluster,
  output logic [NW-1:0]     out_ncons,
  output logic [CODE_W-1:0] out_vowel,
  output logic              out_has_vowel,
  output logic              out_word_end,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CLUSTER,
    BASE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     slots_q, slots_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [CW-1:0]     oclu_q;
  logic [NW-1:0]     oncons_q;
  logic [CODE_W-1:0] ovow_q;
  logic              ohv_q, owe_q, oerr_q, ovalid_q;

  logic              accept, is_cons, is_space;
  logic              ld;
  logic [CW-1:0]     e_clu, app, fresh;
  logic [NW-1:0]     e_ncons;
  logic [CODE_W-1:0] e_vow;
  logic              e_hv, e_we, e_err;

  assign in_ready = !ovalid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_cons  = in_code[CODE_W-1];
  assign is_space = (in_code == SPACE_CODE);

  always_comb begin
    app = slots_q;
    for (int i = 0; i <= MAX_HALF; i++) begin
      if (cnt_q == NW'(i)) app[i*CODE_W +: CODE_W] = in_code;
    end
    fresh = '0;
    fresh[CODE_W-1:0] = in_code;
  end

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld      = 1'b0;
    e_clu   = slots_q;
    e_ncons = cnt_q;
    e_vow   = '0;
    e_hv    = 1'b0;
    e_we    = 1'b0;
    e_err   = err_q;
    if (!is_cons) begin
      e_we  = is_space;
      e_hv  = !is_space;
      e_vow = is_space ? '0 : in_code;
    end
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (is_cons) begin
            slots_d = fresh;
            cnt_d   = NW'(1);
            err_d   = 1'b0;
            state_d = in_half ? CLUSTER : BASE;
          end else begin
            ld      = 1'b1;
            e_clu   = '0;
            e_ncons = '0;
            e_err   = 1'b0;
          end
        end
        CLUSTER: begin
          if (is_cons) begin
            slots_d = app;
            cnt_d   = cnt_q + NW'(1);
            if (!in_half) begin
              state_d = BASE;
            end else if (cnt_q == NW'(MAX_HALF)) begin
              err_d   = 1'b1;
              state_d = BASE;
            end
          end else begin
            // a cluster still ending in halant has no base consonant
            ld      = 1'b1;
            e_err   = 1'b1;
            slots_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
        BASE: begin
          ld = 1'b1;
          if (is_cons) begin
            e_vow   = '0;
            e_hv    = 1'b0;
            e_we    = 1'b0;
            slots_d = fresh;
            cnt_d   = NW'(1);
            err_d   = 1'b0;
            state_d = in_half ? CLUSTER : BASE;
          end else begin
            slots_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      slots_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oclu_q   <= '0;
      oncons_q <= '0;
      ovow_q   <= '0;
      ohv_q    <= 1'b0;
      owe_q    <= 1'b0;
      oerr_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (ld) begin
      oclu_q   <= e_clu;
      oncons_q <= e_ncons;
      ovow_q   <= e_vow;
      ohv_q    <= e_hv;
      owe_q    <= e_we;
      oerr_q   <= e_err;
      ovalid_q <= 1'b1;
    end else if (out_ready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign out_cluster   = oclu_q;
  assign out_ncons     = oncons_q;
  assign out_vowel     = ovow_q;
  assign out_has_vowel = ohv_q;
  assign out_word_end  = owe_q;
  assign out_err       = oerr_q;
  assign out_valid     = ovalid_q;

endmodule

// File: tb/tb_syllable_packer.sv
// Bench for syllable_packer: directed table, hand sequences and
// random traffic against a queue-based syllable model.
module tb_syllable_packer;

  localparam int MAXH = 2;
  localparam logic [6:0] SPC = 7'b0110000;

  typedef struct packed {
    logic [20:0] cluster;
    logic [1:0]  ncons;
    logic [6:0]  vowel;
    logic        hv;
    logic        we;
    logic        err;
  } rec_t;

  typedef struct packed {
    logic [6:0] code;
    logic       half;
    logic       emit;
    rec_t       exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  in_code = '0;
  logic        in_half = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] out_cluster;
  logic [1:0]  out_ncons;
  logic [6:0]  out_vowel;
  logic        out_has_vowel, out_word_end, out_err, out_valid;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  logic [6:0] mq[$];
  bit         based = 0;
  bit         merr = 0;
  rec_t       expq[$];
  vec_t       vq[$];

  syllable_packer dut (
    .clock(clock), .reset(reset),
    .in_code(in_code), .in_half(in_half),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_cluster(out_cluster), .out_ncons(out_ncons),
    .out_vowel(out_vowel), .out_has_vowel(out_has_vowel),
    .out_word_end(out_word_end), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic rec_t mkrec(input logic [6:0] c0, c1, c2,
                                 input logic [1:0] n,
                                 input logic [6:0] v,
                                 input logic hv, we, er);
    rec_t r;
    r.cluster = {c2, c1, c0};
    r.ncons = n;
    r.vowel = v;
    r.hv = hv;
    r.we = we;
    r.err = er;
    return r;
  endfunction

  function automatic rec_t get_rec();
    rec_t r;
    r.cluster = out_cluster;
    r.ncons = out_ncons;
    r.vowel = out_vowel;
    r.hv = out_has_vowel;
    r.we = out_word_end;
    r.err = out_err;
    return r;
  endfunction

  // syllable model: consonants pile up in mq; "based" once a
  // full consonant (or overflowing half) closes the cluster
  function automatic void push_cluster(input logic [6:0] v,
                                       input bit hv, we, er);
    rec_t r;
    r = '0;
    for (int i = 0; i < mq.size(); i++) r.cluster[i*7 +: 7] = mq[i];
    r.ncons = 2'(mq.size());
    r.vowel = v;
    r.hv = hv;
    r.we = we;
    r.err = er;
    expq.push_back(r);
    mq.delete();
    based = 0;
    merr = 0;
  endfunction

  function automatic void model_in(input logic [6:0] c, input logic h);
    bit dangling;
    dangling = (mq.size() > 0) && !based;
    if (c[6]) begin
      if (mq.size() > 0 && based) push_cluster('0, 0, 0, merr);
      if (!h) begin
        mq.push_back(c);
        based = 1;
      end else if (mq.size() == MAXH) begin
        mq.push_back(c);
        based = 1;
        merr = 1;
      end else begin
        mq.push_back(c);
      end
    end else if (c == SPC) begin
      push_cluster('0, 0, 1, merr | dangling);
    end else begin
      push_cluster(c, 1, 0, merr | dangling);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mq.delete();
        expq.delete();
        based = 0;
        merr = 0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid) begin
          if (expq.size() == 0) begin
            chk("unexpected_rec", 1, 0);
          end else begin
            chk("scoreboard_rec", get_rec(), expq[0]);
            if (out_ready) begin
              void'(expq.pop_front());
              n_xfer++;
            end
          end
        end else begin
          chk("no_lost_rec", expq.size(), 0);
        end
        if (in_valid && in_ready) model_in(in_code, in_half);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic h);
    bit acc;
    acc = 0;
    in_code = c;
    in_half = h;
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic add(input logic [6:0] c, input logic h,
                     input logic e, input rec_t r);
    vec_t v;
    v.code = c;
    v.half = h;
    v.emit = e;
    v.exp = r;
    vq.push_back(v);
  endtask

  task automatic send_vyakti();
    send(7'b1011110, 1);
    send(7'b1011011, 0);
    send(7'b0000000, 0);
    send(7'b1000000, 1);
    send(7'b1010001, 0);
    send(7'b0000010, 0);
    send(SPC, 0);
  endtask

  initial begin
    rec_t z, r1;
    int x0;
    bit seen, done;
    logic [6:0] c;
    z = '0;
    r1 = mkrec(7'b1011110, 7'b1011011, 0, 2, 7'b0000000, 1, 0, 0);

    // vyakti
    add(7'b1011110, 1, 0, z);
    add(7'b1011011, 0, 0, z);
    add(7'b0000000, 0, 1, r1);
    add(7'b1000000, 1, 0, z);
    add(7'b1010001, 0, 0, z);
    add(7'b0000010, 0, 1,
        mkrec(7'b1000000, 7'b1010001, 0, 2, 7'b0000010, 1, 0, 0));
    add(SPC, 0, 1, mkrec(0, 0, 0, 0, 0, 0, 1, 0));
    // bare consonants
    add(7'b1000000, 0, 0, z);
    add(7'b1010001, 0, 1, mkrec(7'b1000000, 0, 0, 1, 0, 0, 0, 0));
    add(SPC, 0, 1, mkrec(7'b1010001, 0, 0, 1, 0, 0, 1, 0));
    // overflow
    add(7'b1000001, 1, 0, z);
    add(7'b1000010, 1, 0, z);
    add(7'b1000011, 1, 0, z);
    add(7'b0000010, 0, 1,
        mkrec(7'b1000001, 7'b1000010, 7'b1000011, 3, 7'b0000010, 1, 0, 1));
    // dangling halant
    add(7'b1011110, 1, 0, z);
    add(SPC, 0, 1, mkrec(7'b1011110, 0, 0, 1, 0, 0, 1, 1));

    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_rec", get_rec(), z);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    foreach (vq[i]) begin
      send(vq[i].code, vq[i].half);
      chk($sformatf("vec%0d_valid", i), out_valid, vq[i].emit);
      if (vq[i].emit) chk($sformatf("vec%0d_rec", i), get_rec(), vq[i].exp);
    end
    tick();

    // backpressure on the vyakti word
    x0 = n_xfer;
    seen = 0;
    fork
      send_vyakti();
      begin
        for (int k = 0; k < 100 && !seen; k++) begin
          tick();
          seen = out_valid;
        end
        chk("bp_first_seen", seen, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_rec", get_rec(), r1);
          chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("bp_count", n_xfer - x0, 3);

    // reset mid-cluster
    send(7'b1011110, 1);
    reset = 1'b1;
    tick();
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    reset = 1'b0;
    send(7'b0000010, 0);
    chk("rstmid_next_valid", out_valid, 1);
    chk("rstmid_next_rec", get_rec(),
        mkrec(0, 0, 0, 0, 7'b0000010, 1, 0, 0));
    tick();

    // reset while a record is pending
    out_ready = 1'b0;
    send(7'b0000011, 0);
    chk("rstpend_pre", out_valid, 1);
    reset = 1'b1;
    tick();
    chk("rstpend_valid", out_valid, 0);
    chk("rstpend_rec", get_rec(), z);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // random traffic with random consumer stalls
    done = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          case ($urandom_range(0, 19)) inside
            [0:9]: send({1'b1, 6'($urandom)}, 1'($urandom));
            [10:16]: begin
              c = {1'b0, 6'($urandom)};
              if (c == SPC) c = '0;
              send(c, 1'($urandom));
            end
            default: send(SPC, 1'($urandom));
          endcase
        end
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    send(SPC, 0);
    repeat (4) tick();
    chk("drain_queue", expq.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/syllable_packer.md
Name: syllable_packer

Overview:
- Sits directly downstream of the Devanagari Encoder.
- Consumes the stream of 7-bit letter codes the Encoder produces, each tagged with a half (halant) flag.
- Assembles them into complete syllable records: conjunct cluster, optional vowel sign and word-end flag.
- Records are handed to the glyph/render stage over a valid/ready handshake.

Parameters:
- CODE_W, 7: letter code width.
- MAX_HALF, 2: maximum number of half consonants preceding the base consonant in one cluster.
- SPACE_CODE, 7'b0110000: word separator code.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_code  in  CODE_W  letter code from the Encoder.
- in_half  in  1  1 = consonant is a half form (halant attached).
- in_valid  in  1  in_code/in_half are valid this cycle.
- in_ready  out  1  block accepts input this cycle; transfer occurs when in_valid && in_ready.
- out_cluster  out  (MAX_HALF+1)*CODE_W  consonants in arrival order; first consonant in bits [CODE_W-1:0]; unused slots are zero.
- out_ncons  out  $clog2(MAX_HALF+2)  number of consonants in out_cluster (0..MAX_HALF+1).
- out_vowel  out  CODE_W  attached vowel code; zero if none.
- out_has_vowel  out  1  out_vowel is meaningful.
- out_word_end  out  1  record terminates a word.
- out_err  out  1  record was malformed (see below).
- out_valid  out  1  record valid; held stable until accepted.
- out_ready  in  1  consumer accepts the record.

Behaviour:
- Classification of an accepted code:
  - in_code[6]=1: consonant.
  - in_code == SPACE_CODE: space.
  - otherwise: vowel (7'b0000000 is the explicit 'a').
  - in_half is ignored for non-consonants.
- Output register:
  - Loaded when a record is emitted.
  - out_valid clears on out_valid && out_ready unless a new record loads in the same cycle; a new load wins.
- in_ready = !out_valid || out_ready. Input is never dropped.
- Assembly FSM: IDLE, CLUSTER, BASE. Assembly registers hold the consonant slots and a count.
- IDLE:
  - Half consonant: store in slot 0, count=1, go to CLUSTER.
  - Full consonant: store in slot 0, go to BASE.
  - Vowel: emit {ncons=0, vowel, has_vowel=1}, stay in IDLE.
  - Space: emit {ncons=0, word_end=1}, stay in IDLE.
- CLUSTER:
  - Half consonant with count<MAX_HALF: append.
  - Half consonant with count==MAX_HALF: append as the base, set the err flag for this syllable, go to BASE.
  - Full consonant: append, go to BASE.
  - Vowel: emit the cluster with the vowel and err=1, go to IDLE.
  - Space: emit the cluster with word_end=1 and err=1 (dangling halant), go to IDLE.
- BASE:
  - Vowel: emit the cluster with the vowel, go to IDLE.
  - Space: emit the cluster with no vowel (inherent 'a') and word_end=1, go to IDLE.
  - Consonant: emit the current cluster with no vowel. In the same cycle, load the new consonant into slot 0 of the freshly cleared assembly registers, then go to CLUSTER or BASE per in_half.
- Latency: a record appears on out_* the cycle after its terminating input is accepted.
  - A syllable ending in a bare consonant stays buffered until the next input arrives.
- Back-to-back: one record may be emitted per cycle when out_ready=1 continuously.
- Reset:
  - Outputs after reset: out_valid=0, all out_* fields zero, in_ready=1, FSM in IDLE.
  - Asserting reset mid-syllable or while out_valid=1 discards the partial syllable and the pending record.

Test Plan:
- Word "vyakti": send (1011110,h=1), (1011011,h=0), (0000000), (1000000,h=1), (1010001,h=0), (0000010), (0110000) with out_ready=1. Required records:
  - {cluster=1011110,1011011; ncons=2; vowel=0000000}
  - {cluster=1000000,1010001; ncons=2; vowel=0000010}
  - {ncons=0; word_end=1}
  - out_err=0 on all three.
- Bare consonants: send 1000000(h=0), 1010001(h=0), space. Required records:
  - {1000000, ncons=1, has_vowel=0} emitted on acceptance of 1010001.
  - {1010001, ncons=1, word_end=1} emitted on acceptance of the space.
- Backpressure: same stimulus as the "vyakti" case with out_ready=0 for 5 cycles after the first record. Required:
  - First record held stable.
  - in_ready=0 whenever a second record is pending.
  - No record lost or duplicated once out_ready=1.
- Cluster overflow with MAX_HALF=2: send three half consonants, then 0000010. Required: one record with ncons=3, vowel=0000010, out_err=1.
- Dangling halant: send 1011110(h=1), then space. Required: {ncons=1, word_end=1, out_err=1}.
- Reset mid-cluster: send 1011110(h=1), assert reset for one cycle, then send 0000010. Required:
  - out_valid=0 through reset.
  - Next record is {ncons=0, vowel=0000010}.
